sram_ctrl: RTL and testbench

- Request/response front-end for the DE1 off-chip 256Kx16 asynchronous SRAM.
- Sits between user logic (pattern generators, LED display logic) and the SRAM_* board pins, and owns all pin timing.
- Accepts single read/write commands over a valid/ready handshake and generates glitch-free WE_N/OE_N/UB_N/LB_N sequences with bus turnaround.
- Returns read data with a one-cycle response pulse.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_io.sv | 38 +++
 rtl/sram_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the DE1 async SRAM front-end.
// Pulled in by sram_ctrl and sram_io.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W       = 18;
   localparam int unsigned SRAM_DATA_W       = 16;
   localparam int unsigned SRAM_WAIT_DEFAULT = 1;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_ACCESS,
      TURN
   } state_t;

endpackage

// File: rtl/sram_io.sv
// DQ tristate driver and byte-masked read-capture register for the async SRAM.
// Every pin-facing signal in this module comes straight from a flop.
module sram_io
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W = SRAM_DATA_W
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              drive_load,
   input  logic [DATA_W-1:0] drive_data,
   input  logic              drive_en,
   input  logic              cap_en,
   input  logic [1:0]        cap_be,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] dq_out;
   logic              dq_oe;
   logic [DATA_W-1:0] cap_mask;

   assign cap_mask = {{(DATA_W/2){cap_be[1]}}, {(DATA_W/2){cap_be[0]}}};
   assign SRAM_DQ  = dq_oe ? dq_out : {DATA_W{1'bz}};

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         dq_out <= '0;
         dq_oe  <= 1'b0;
         rdata  <= '0;
      end else begin
         dq_oe <= drive_en;
         if (drive_load) dq_out <= drive_data;
         if (cap_en)     rdata  <= SRAM_DQ & cap_mask;
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready front-end for the DE1 256Kx16 async SRAM.
// Owns pin sequencing: write setup/pulse/hold, read access and bus turnaround.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W      = SRAM_ADDR_W,
   parameter int unsigned DATA_W      = SRAM_DATA_W,
   parameter int unsigned WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_CE_N
);

   state_t     state;
   logic [3:0] cnt;
   logic [1:0] be_q;
   logic       drive_load;
   logic       drive_en;
   logic       cap_en;

   assign req_ready  = (state == IDLE);
   assign drive_load = req_ready && req_valid && req_we;
   // DQ enable is registered in sram_io, so this is its next-cycle value.
   assign drive_en   = drive_load || (state == W_SETUP) || (state == W_PULSE);
   assign cap_en     = (state == R_ACCESS) && !SRAM_OE_N && (cnt == 4'd0);

   always_ff @(posedge CLOCK_50) begin
      rsp_valid <= 1'b0;
      if (RESET) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         be_q      <= 2'b00;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
         SRAM_CE_N <= 1'b1;
      end else begin
         SRAM_CE_N <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  SRAM_ADDR <= req_addr;
                  be_q      <= req_be;
                  SRAM_UB_N <= ~req_be[1];
                  SRAM_LB_N <= ~req_be[0];
                  cnt       <= 4'(WAIT_CYCLES);
                  state     <= req_we ? W_SETUP : R_ACCESS;
               end
            end
            W_SETUP: begin
               SRAM_WE_N <= 1'b0;
               cnt       <= 4'(WAIT_CYCLES);
               state     <= W_PULSE;
            end
            W_PULSE: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  SRAM_WE_N <= 1'b1;
                  state     <= W_HOLD;
               end
            end
            W_HOLD: begin
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               state     <= IDLE;
            end
            // First R_ACCESS cycle lets the address settle before OE_N falls.
            R_ACCESS: begin
               if (SRAM_OE_N) begin
                  SRAM_OE_N <= 1'b0;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  SRAM_OE_N <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= TURN;
               end
            end
            TURN: begin
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sram_io #(
      .DATA_W (DATA_W)
   ) u_io (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .drive_load (drive_load),
      .drive_data (req_wdata),
      .drive_en   (drive_en),
      .cap_en     (cap_en),
      .cap_be     (be_q),
      .SRAM_DQ    (SRAM_DQ),
      .rdata      (rsp_rdata)
   );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 1, 0, 3), each on a behavioural async SRAM,
// checked against a word-level reference memory and per-transaction timing rules.
module tb_sram_ctrl;

   localparam logic [17:0] SENT = 18'h2AAAA;

   logic CLOCK_50 = 1'b0;
   logic RESET;
   bit   model_on;

   logic        req_valid [3];
   logic        req_we    [3];
   logic [17:0] req_addr  [3];
   logic [15:0] req_wdata [3];
   logic [1:0]  req_be    [3];
   logic        req_ready [3];
   logic        rsp_valid [3];
   logic [15:0] rsp_rdata [3];
   logic [17:0] sram_addr [3];
   logic        we_n [3];
   logic        oe_n [3];
   logic        ub_n [3];
   logic        lb_n [3];
   logic        ce_n [3];
   logic        dut_oe [3];

   int n_checks = 0;
   int n_errors = 0;
   int bus_err [3];
   bit prev_oe_low [3];

   logic [15:0] ref_mem [int];

   always #10 CLOCK_50 = ~CLOCK_50;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wire  [15:0] dq;
      logic [15:0] mem [0:262143];

      initial for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

      assign dq        = (!oe_n[g] && !ce_n[g]) ? mem[sram_addr[g]] : 16'bz;
      assign dut_oe[g] = u_dut.u_io.dq_oe;

      always @(posedge we_n[g]) begin
         if (model_on && !ce_n[g]) begin
            if (!ub_n[g]) mem[sram_addr[g]][15:8] <= dq[15:8];
            if (!lb_n[g]) mem[sram_addr[g]][7:0]  <= dq[7:0];
         end
      end

      sram_ctrl #(
         .ADDR_W      (18),
         .DATA_W      (16),
         .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) u_dut (
         .CLOCK_50  (CLOCK_50),
         .RESET     (RESET),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .SRAM_ADDR (sram_addr[g]),
         .SRAM_DQ   (dq),
         .SRAM_WE_N (we_n[g]),
         .SRAM_OE_N (oe_n[g]),
         .SRAM_UB_N (ub_n[g]),
         .SRAM_LB_N (lb_n[g]),
         .SRAM_CE_N (ce_n[g])
      );
   end

   // Controller must never drive DQ while OE_N is low or in the cycle right after.
   always @(negedge CLOCK_50) begin
      for (int i = 0; i < 3; i++) begin
         if (dut_oe[i] && (!oe_n[i] || prev_oe_low[i])) bus_err[i] <= bus_err[i] + 1;
         prev_oe_low[i] <= !oe_n[i];
      end
   end

   function automatic int wait_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   function automatic logic [15:0] lane_mask(input logic [1:0] be);
      return {{8{be[1]}}, {8{be[0]}}};
   endfunction

   function automatic logic [15:0] ref_read(input int d, input logic [17:0] a);
      int key = d * 262144 + int'(a);
      return ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
   endfunction

   function automatic void ref_write(input int d, input logic [17:0] a, input logic [15:0] wd,
                                     input logic [1:0] be);
      logic [15:0] m = lane_mask(be);
      ref_mem[d * 262144 + int'(a)] = (ref_read(d, a) & ~m) | (wd & m);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input int d);
      check_eq("rst_pins", {27'd0, we_n[d], oe_n[d], ub_n[d], lb_n[d], ce_n[d]}, 32'h1f);
      check_eq("rst_dq_released", {31'd0, dut_oe[d]}, 32'd0);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check_eq("rst_addr", {14'd0, sram_addr[d]}, 32'd0);
      check_eq("rst_rdata", {16'd0, rsp_rdata[d]}, 32'd0);
   endtask

   // Call at a negedge. Returns at the negedge where req_ready is seen again.
   task automatic txn(input int d, input bit we, input logic [17:0] a, input logic [15:0] wd,
                      input logic [1:0] be, input bit hold, input bit noise,
                      output logic [15:0] rd);
      int w = wait_of(d);
      int we_low = 0, oe_low = 0, rsp_cnt = 0, rsp_k = -1, rdy_k = -1, lane_err = 0;
      bit acc = 1'b0;
      logic [15:0] exp_rd;
      rd = 16'h0000;
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_be[d]    = be;
      for (int t = 0; t < 50 && !acc; t++) begin
         acc = req_ready[d];
         @(negedge CLOCK_50);
      end
      if (!acc) begin
         check_eq("accept_timeout", 32'd0, 32'd1);
         req_valid[d] = 1'b0;
         return;
      end
      exp_rd = ref_read(d, a) & lane_mask(be);
      if (we) ref_write(d, a, wd, be);
      if (!hold) req_valid[d] = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (!we_n[d]) we_low++;
         if (!oe_n[d]) oe_low++;
         if (rsp_valid[d]) begin
            rsp_cnt++;
            if (rsp_k < 0) rsp_k = k;
            rd = rsp_rdata[d];
         end
         if (req_ready[d]) begin
            rdy_k = k;
            break;
         end
         if ({ub_n[d], lb_n[d]} != ~be) lane_err++;
         if (noise) begin
            req_valid[d] = 1'($urandom);
            req_we[d]    = 1'b1;
            req_addr[d]  = SENT;
            req_wdata[d] = 16'($urandom);
         end
         @(negedge CLOCK_50);
      end
      if (!hold) req_valid[d] = 1'b0;
      check_eq("ready_return", rdy_k, w + 3);
      check_eq("byte_lanes", lane_err, 0);
      if (we) begin
         check_eq("we_low_cycles", we_low, w + 1);
         check_eq("wr_oe_low", oe_low, 0);
         check_eq("wr_rsp_count", rsp_cnt, 0);
      end else begin
         check_eq("rd_we_low", we_low, 0);
         check_eq("oe_low_cycles", oe_low, w + 1);
         check_eq("rsp_cycle", rsp_k, w + 2);
         check_eq("rsp_count", rsp_cnt, 1);
         check_eq("rd_data", {16'd0, rd}, {16'd0, exp_rd});
      end
   endtask

   initial begin
      logic [15:0] rd;
      logic [17:0] a;
      RESET    = 1'b1;
      model_on = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_be[i]    = '0;
         bus_err[i]   = 0;
      end
      repeat (3) @(negedge CLOCK_50);
      for (int i = 0; i < 3; i++) check_reset(i);
      RESET    = 1'b0;
      model_on = 1'b1;
      @(negedge CLOCK_50);
      check_eq("post_rst_ready", {31'd0, req_ready[0]}, 32'd1);

      // Test 1: reset in the write setup cycle drops the write
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 18'd100;
      req_wdata[0] = 16'hBEEF;
      req_be[0]    = 2'b11;
      @(negedge CLOCK_50);
      req_valid[0] = 1'b0;
      check_eq("t1_busy", {31'd0, req_ready[0]}, 32'd0);
      RESET = 1'b1;
      repeat (3) begin
         @(negedge CLOCK_50);
         check_reset(0);
      end
      RESET = 1'b0;
      @(negedge CLOCK_50);
      check_eq("t1_ready", {31'd0, req_ready[0]}, 32'd1);
      check_eq("t1_ce_low", {31'd0, ce_n[0]}, 32'd0);
      check_eq("t1_mem_kept", {16'd0, g_dut[0].mem[100]}, {16'd0, ref_read(0, 18'd100)});

      // Test 2: write then read
      txn(0, 1'b1, 18'd13, 16'd50, 2'b11, 1'b0, 1'b0, rd);
      txn(0, 1'b0, 18'd13, 16'd0, 2'b11, 1'b0, 1'b0, rd);
      check_eq("t2_rdata", {16'd0, rd}, 32'd50);

      // Test 3: byte lanes at the top address
      txn(0, 1'b1, 18'h3FFFF, 16'hABCD, 2'b11, 1'b0, 1'b0, rd);
      txn(0, 1'b1, 18'h3FFFF, 16'h1200, 2'b10, 1'b0, 1'b0, rd);
      txn(0, 1'b0, 18'h3FFFF, 16'h0000, 2'b01, 1'b0, 1'b0, rd);
      check_eq("t3_rdata", {16'd0, rd}, 32'h00CD);
      txn(0, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 1'b0, 1'b0, rd);
      check_eq("t3_full", {16'd0, rd}, 32'h12CD);

      // Test 4: back-to-back alternating write/read with req_valid held high
      for (int i = 0; i < 8; i++) begin
         a = 18'(i * 97 + $urandom_range(0, 90));
         txn(0, 1'b1, a, 16'($urandom), 2'($urandom), 1'b1, 1'b0, rd);
         txn(0, 1'b0, a, 16'h0000, 2'($urandom), 1'b1, 1'b0, rd);
      end
      req_valid[0] = 1'b0;
      @(negedge CLOCK_50);

      // Test 5: WAIT_CYCLES = 0 and 3
      for (int d = 1; d < 3; d++) begin
         repeat (3) begin
            a = 18'($urandom_range(0, 1023));
            txn(d, 1'b1, a, 16'($urandom), 2'($urandom_range(1, 3)), 1'b0, 1'b0, rd);
            txn(d, 1'b0, a, 16'h0000, 2'($urandom), 1'b0, 1'b0, rd);
         end
      end

      // Test 6: be = 0 read and requests toggled while busy
      txn(0, 1'b0, 18'd13, 16'h0000, 2'b00, 1'b0, 1'b0, rd);
      check_eq("t6_be0_rdata", {16'd0, rd}, 32'd0);
      repeat (8) begin
         txn(0, 1'($urandom), 18'($urandom_range(0, 1023)), 16'($urandom), 2'($urandom),
             1'b0, 1'b1, rd);
      end
      txn(0, 1'b0, SENT, 16'h0000, 2'b11, 1'b0, 1'b0, rd);
      check_eq("t6_sentinel", {16'd0, rd}, 32'd0);

      repeat (2) @(negedge CLOCK_50);
      for (int i = 0; i < 3; i++) check_eq("bus_contention", bus_err[i], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
